ip_sel_switch_ctrl: RTL and testbench
=====================================

Name: ip_sel_switch_ctrl

Overview:
Sequences run-time changes of the IP selection driven by the ip_sel pads. The raw select is synchronised and debounced, then the switch runs a safe sequence: isolate the pads, hold every IP in reset, update the mux select, then release only the chosen IP. It sits in the ASIC top between the ip_sel pads and the pad-mux/IP reset logic, replacing direct combinational use of the raw select.

Parameters:
NUM_IP, 7, number of selectable IPs; select value i (1..NUM_IP) picks IP i, 0 = none
SYNC_STAGES, 2, synchroniser depth for ip_sel_raw (minimum 2)
DEBOUNCE_CYC, 1024, consecutive equal synchronised samples needed to accept a new select
ISO_CYC, 4, cycles pads stay isolated before resets assert
RST_CYC, 16, cycles of reset hold, and cycles of post-release settle

Ports:
sys_clk  in  1  the block's single clock
rst_n  in  1  asynchronous active-low reset
ip_sel_raw  in  3  unsynchronised select from pads
sel_lock  in  1  when 1, new stable selects are not acted on
ip_sel_active  out  3  select driven to the pad mux; 0 = no IP
ip_rst_n  out  NUM_IP  per-IP active-low reset; bit i-1 belongs to IP i
pad_oe_en  out  1  global gate on mux output-enables
busy  out  1  switch sequence in progress
switch_done  out  1  one-cycle pulse when a sequence completes
sel_invalid  out  1  debounced select value > NUM_IP

Behaviour:
- Reset values (async, while rst_n=0):
  - ip_sel_active=0, ip_rst_n=all 0, pad_oe_en=0, busy=0, switch_done=0, sel_invalid=0.
  - Synchroniser flops, debounced select, target and counters all cleared to 0.
  - State = STABLE.
- Synchroniser: SYNC_STAGES flops on sys_clk.
- Debounce:
  - The counter clears whenever the synchronised value differs from the previous sample.
  - When DEBOUNCE_CYC consecutive equal samples are seen, stable_sel takes that value.
  - Values > NUM_IP map to stable_sel=0 and set sel_invalid=1; sel_invalid clears when a valid value is debounced.
- State machine:
  - STABLE:
    - busy=0.
    - If stable_sel != ip_sel_active and sel_lock=0, capture target=stable_sel and go to ISOLATE on the next edge.
    - pad_oe_en=1 iff ip_sel_active!=0.
  - ISOLATE: pad_oe_en=0, busy=1; stay ISO_CYC cycles, then go to HOLD_RST.
  - HOLD_RST: ip_rst_n=all 0; stay RST_CYC cycles, then go to SELECT.
  - SELECT: one cycle; ip_sel_active<=target.
  - RELEASE:
    - ip_rst_n[target-1]=1 (all stay 0 if target=0); stay RST_CYC cycles.
    - Then go to STABLE with switch_done=1 for exactly one cycle.
    - pad_oe_en returns to 1 in that same cycle if target!=0.
- Latency: from the cycle STABLE sees a mismatch to the switch_done pulse = 1 + ISO_CYC + RST_CYC + 1 + RST_CYC cycles (38 with defaults).
- Invariants:
  - pad_oe_en is never 1 when state != STABLE.
  - At most one ip_rst_n bit is 1.
  - ip_sel_active changes only in SELECT.
- Simultaneous or mid-sequence events:
  - target is frozen once ISOLATE is entered; stable_sel may keep changing.
  - On return to STABLE, a new mismatch starts a fresh sequence on the next cycle.
  - switch_done and a new start are never in the same cycle.
- sel_lock:
  - Sampled only in STABLE.
  - Asserting it mid-sequence does not abort the sequence.
- Re-selecting the current IP (stable_sel == ip_sel_active): no sequence runs.
- Reset mid-sequence: immediate return to the reset values. After deassertion, a nonzero pad select is re-debounced and switched normally.
- Counters are sized $clog2 of the largest of DEBOUNCE_CYC, ISO_CYC, RST_CYC, plus 1 bit; no wrap-around in any state.

Decomposition:
- Shared package ip_sel_pkg: state enum (STABLE, ISOLATE, HOLD_RST, SELECT, RELEASE), IP_SEL_W=3, IP_NONE=3'd0, IP_SOC1=3'd1.
- One sub-module ip_sel_sync_debounce holds the synchroniser, debounce counter and invalid mapping. Its outputs are stable_sel and sel_invalid.

Test Plan (bench uses DEBOUNCE_CYC=8, ISO_CYC=4, RST_CYC=16, NUM_IP=7):
1. Reset then ip_sel_raw=1 held -> after sync (2) + debounce (8) the sequence starts. pad_oe_en stays 0 throughout. ip_sel_active=1 after SELECT. ip_rst_n=7'b0000001 in RELEASE. switch_done pulses 38 cycles after start and pad_oe_en=1 in that cycle.
2. Active=1, raw toggles 1->2->1 with glitch width 5 cycles -> no sequence, busy stays 0, ip_rst_n unchanged.
3. Active=1, raw=3 stable -> ip_rst_n all 0 for 16 cycles. Then ip_sel_active=3 and ip_rst_n=7'b0000100. One switch_done pulse.
4. During the sequence to 3, raw changes to 5 and is debounced -> completes to 3, switch_done, then next cycle busy=1 and the sequence ends at ip_sel_active=5.
5. raw=7'h? value 6 with NUM_IP=5 override, or raw=0 -> sel_invalid=1 for value 6 and the target is 0. All ip_rst_n=0 and pad_oe_en=0 at the end.
6. sel_lock=1 then raw=4 stable -> no switch. Drop sel_lock -> sequence starts the next cycle. Assert rst_n=0 at HOLD_RST cycle 5 -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/ip_sel_switch_ctrl_pkg.sv
// Shared types and constants for the IP-select switch controller and its
// synchroniser/debounce front end.
package ip_sel_pkg;

  localparam int IP_SEL_W = 3;
  localparam logic [IP_SEL_W-1:0] IP_NONE = 3'd0;
  localparam logic [IP_SEL_W-1:0] IP_SOC1 = 3'd1;

  typedef enum logic [2:0] {
    STABLE,
    ISOLATE,
    HOLD_RST,
    SELECT,
    RELEASE
  } sw_state_e;

  // Counter width that holds the longest of the three phase lengths without wrapping.
  function automatic int cnt_width(input int deb_cyc, input int iso_cyc, input int rst_cyc);
    int m;
    m = deb_cyc;
    if (iso_cyc > m) m = iso_cyc;
    if (rst_cyc > m) m = rst_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ip_sel_switch_ctrl_if.sv
// Pad-side select inputs and pad-mux / IP-reset outputs of the switch controller.
interface ip_sel_switch_ctrl_if #(
  parameter int NUM_IP = 7
);

  logic [ip_sel_pkg::IP_SEL_W-1:0] ip_sel_raw;
  logic                            sel_lock;
  logic [ip_sel_pkg::IP_SEL_W-1:0] ip_sel_active;
  logic [NUM_IP-1:0]               ip_rst_n;
  logic                            pad_oe_en;
  logic                            busy;
  logic                            switch_done;
  logic                            sel_invalid;

  modport master (
    output ip_sel_raw, sel_lock,
    input  ip_sel_active, ip_rst_n, pad_oe_en, busy, switch_done, sel_invalid
  );

  modport slave (
    input  ip_sel_raw, sel_lock,
    output ip_sel_active, ip_rst_n, pad_oe_en, busy, switch_done, sel_invalid
  );

endinterface

// File: rtl/ip_sel_sync_debounce.sv
// Synchronises the raw pad select and accepts a value only after it has been
// seen unchanged for DEBOUNCE_CYC consecutive samples.
module ip_sel_sync_debounce
  import ip_sel_pkg::*;
#(
  parameter int NUM_IP       = 7,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int CNT_W        = 11
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [IP_SEL_W-1:0] ip_sel_raw,
  output logic [IP_SEL_W-1:0] stable_sel,
  output logic                sel_invalid
);

  localparam logic [CNT_W-1:0]    DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [IP_SEL_W-1:0] MAX_SEL  = IP_SEL_W'(NUM_IP);

  logic [SYNC_STAGES-1:0][IP_SEL_W-1:0] sync_q, sync_d;
  logic [IP_SEL_W-1:0]                  prev_q, prev_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [IP_SEL_W-1:0]                  stable_q, stable_d;
  logic                                 invalid_q, invalid_d;
  logic [IP_SEL_W-1:0]                  sync_val;

  assign sync_val = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    sync_d    = {sync_q[SYNC_STAGES-2:0], ip_sel_raw};
    prev_d    = sync_val;
    cnt_d     = '0;
    stable_d  = stable_q;
    invalid_d = invalid_q;

    // cnt counts equal samples beyond the first; it saturates instead of wrapping.
    if (sync_val == prev_q) begin
      cnt_d = (cnt_q == DEB_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    end

    if (cnt_d == DEB_LAST) begin
      if (sync_val > MAX_SEL) begin
        stable_d  = IP_NONE;
        invalid_d = 1'b1;
      end else begin
        stable_d  = sync_val;
        invalid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= IP_NONE;
      invalid_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      invalid_q <= invalid_d;
    end
  end

  assign stable_sel  = stable_q;
  assign sel_invalid = invalid_q;

endmodule

// File: rtl/ip_sel_switch_ctrl.sv
// Sequences a change of IP selection: isolate pads, hold all IPs in reset,
// switch the mux select, then release only the chosen IP.
module ip_sel_switch_ctrl
  import ip_sel_pkg::*;
#(
  parameter int NUM_IP       = 7,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int ISO_CYC      = 4,
  parameter int RST_CYC      = 16
) (
  input logic                 sys_clk,
  input logic                 rst_n,
  ip_sel_switch_ctrl_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYC, ISO_CYC, RST_CYC);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);

  logic [IP_SEL_W-1:0] stable_sel;
  logic                sel_invalid;

  sw_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IP_SEL_W-1:0] target_q, target_d;
  logic [IP_SEL_W-1:0] active_q, active_d;
  logic [NUM_IP-1:0]   ip_rst_n_q, ip_rst_n_d;
  logic                pad_oe_en_q, pad_oe_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  ip_sel_sync_debounce #(
    .NUM_IP      (NUM_IP),
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_sync_debounce (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .ip_sel_raw (bus.ip_sel_raw),
    .stable_sel (stable_sel),
    .sel_invalid(sel_invalid)
  );

  function automatic logic [NUM_IP-1:0] sel_onehot(input logic [IP_SEL_W-1:0] sel);
    sel_onehot = '0;
    for (int i = int'(IP_SOC1); i <= NUM_IP; i++) begin
      if (sel == IP_SEL_W'(i)) sel_onehot[i-1] = 1'b1;
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    active_d = active_q;
    done_d   = 1'b0;

    unique case (state_q)
      STABLE: begin
        // target is frozen from here on; later stable_sel changes wait for the next pass.
        if (stable_sel != active_q && !bus.sel_lock) begin
          target_d = stable_sel;
          cnt_d    = '0;
          state_d  = ISOLATE;
        end
      end
      ISOLATE: begin
        if (cnt_q == ISO_LAST) begin
          cnt_d   = '0;
          state_d = HOLD_RST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = SELECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SELECT: begin
        active_d = target_q;
        cnt_d    = '0;
        state_d  = RELEASE;
      end
      RELEASE: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = STABLE;
    endcase

    // Outputs are decoded from the next state so the pads see glitch-free flops.
    busy_d      = (state_d != STABLE);
    pad_oe_en_d = (state_d == STABLE) && (active_d != IP_NONE);
    ip_rst_n_d  = '0;
    if (state_d inside {STABLE, ISOLATE, RELEASE}) ip_rst_n_d = sel_onehot(active_d);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= STABLE;
      cnt_q       <= '0;
      target_q    <= IP_NONE;
      active_q    <= IP_NONE;
      ip_rst_n_q  <= '0;
      pad_oe_en_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      active_q    <= active_d;
      ip_rst_n_q  <= ip_rst_n_d;
      pad_oe_en_q <= pad_oe_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.ip_sel_active = active_q;
  assign bus.ip_rst_n      = ip_rst_n_q;
  assign bus.pad_oe_en     = pad_oe_en_q;
  assign bus.busy          = busy_q;
  assign bus.switch_done   = done_q;
  assign bus.sel_invalid   = sel_invalid;

endmodule

// File: tb/tb_ip_sel_switch_ctrl.sv
// Bench for ip_sel_switch_ctrl: a timeline model checked every cycle, directed
// scenarios with literal expectations, a random phase, and a NUM_IP=5 instance.
module tb_ip_sel_switch_ctrl;

  localparam int NUM_IP   = 7;
  localparam int SYNC     = 2;
  localparam int DEB      = 8;
  localparam int ISO      = 4;
  localparam int RST      = 16;
  localparam int REL_AGE  = 1 + ISO + RST + 1;        // first RELEASE cycle of a sequence
  localparam int DONE_AGE = 1 + ISO + RST + 1 + RST;  // cycle carrying switch_done (38)

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  ip_sel_switch_ctrl_if #(.NUM_IP(NUM_IP)) bus ();
  ip_sel_switch_ctrl_if #(.NUM_IP(5))      bus5 ();

  ip_sel_switch_ctrl #(
    .NUM_IP(NUM_IP), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .ISO_CYC(ISO), .RST_CYC(RST)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus)
  );

  ip_sel_switch_ctrl #(
    .NUM_IP(5), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB), .ISO_CYC(ISO), .RST_CYC(RST)
  ) dut5 (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: a sequence is a fixed timeline indexed by its age in cycles (0 = idle).
  int m_hist [SYNC];
  int m_prev, m_run, m_stable, m_inv, m_active, m_tgt, m_age;
  bit m_done;

  function automatic int onehot(input int sel);
    return (sel == 0) ? 0 : (1 << (sel - 1));
  endfunction

  always @(posedge sys_clk or negedge rst_n) begin
    int s;
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = 0;
      m_prev = 0; m_run = 1; m_stable = 0; m_inv = 0;
      m_active = 0; m_tgt = 0; m_age = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_age == 0) begin
        if (m_stable != m_active && !bus.sel_lock) begin
          m_age = 1;
          m_tgt = m_stable;
        end
      end else begin
        m_age++;
        if (m_age == REL_AGE) m_active = m_tgt;
        if (m_age == DONE_AGE) begin
          m_age  = 0;
          m_done = 1;
        end
      end
      s = m_hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = int'(bus.ip_sel_raw);
      // The all-zero state left by reset counts as the previous sample.
      m_run  = (s == m_prev) ? ((m_run < DEB) ? m_run + 1 : DEB) : 1;
      m_prev = s;
      if (m_run == DEB) begin
        m_inv    = (s > NUM_IP) ? 1 : 0;
        m_stable = (s > NUM_IP) ? 0 : s;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (rst_n) begin
      check("active", bus.ip_sel_active, m_active);
      check("ip_rst_n", bus.ip_rst_n,
            (m_age > ISO && m_age < REL_AGE) ? 0 : onehot(m_active));
      check("pad_oe_en", bus.pad_oe_en, (m_age == 0 && m_active != 0) ? 1 : 0);
      check("busy", bus.busy, (m_age != 0) ? 1 : 0);
      check("switch_done", bus.switch_done, m_done);
      check("sel_invalid", bus.sel_invalid, m_inv);
    end
  end

  // which: 0 = busy high, 1 = switch_done high. A timeout is a failed check.
  task automatic wait_for(input int which, input int budget, output int waited);
    bit hit;
    hit = 0;
    waited = 0;
    while (!hit && waited < budget) begin
      @(negedge sys_clk);
      waited++;
      hit = (which == 0) ? bus.busy : bus.switch_done;
    end
    check($sformatf("wait%0d_reached", which), hit, 1);
  endtask

  task automatic set_raw(input int v);
    @(negedge sys_clk);
    bus.ip_sel_raw = 3'(v);
  endtask

  initial begin
    int w, zero_cyc, busy_cyc;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, zero_cyc, busy_cyc;
    bus.ip_sel_raw  = '0;
    bus.sel_lock    = 1'b0;
    bus5.ip_sel_raw = '0;
    bus5.sel_lock   = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_active", bus.ip_sel_active, 0);
    check("rst_ip_rst_n", bus.ip_rst_n, 0);
    check("rst_oe", bus.pad_oe_en, 0);
    check("rst_busy", bus.busy, 0);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge sys_clk);

    // 1: first switch to IP 1
    bus.ip_sel_raw = 3'd1;
    wait_for(0, 40, w);
    check("t1_start_delay", w, 11);
    repeat (REL_AGE - 1) @(negedge sys_clk);
    check("t1_rel_active", bus.ip_sel_active, 1);
    check("t1_rel_rst", bus.ip_rst_n, 7'b0000001);
    check("t1_rel_oe", bus.pad_oe_en, 0);
    wait_for(1, 40, w);
    check("t1_latency", REL_AGE + w, 38);
    check("t1_done_oe", bus.pad_oe_en, 1);

    // 2: a 5-cycle glitch must not be accepted
    repeat (5) @(negedge sys_clk);
    set_raw(2);
    repeat (4) @(negedge sys_clk);
    bus.ip_sel_raw = 3'd1;
    busy_cyc = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (bus.busy) busy_cyc++;
    end
    check("t2_busy_cycles", busy_cyc, 0);
    check("t2_rst", bus.ip_rst_n, 7'b0000001);

    // 3: switch to IP 3, counting fully-held reset cycles (HOLD + SELECT)
    set_raw(3);
    wait_for(0, 40, w);
    check("t3_start_delay", w, 11);
    zero_cyc = 0;
    w = 0;
    while (!bus.switch_done && w < 60) begin
      if (bus.ip_rst_n == 0) zero_cyc++;
      @(negedge sys_clk);
      w++;
    end
    check("t3_done_seen", bus.switch_done, 1);
    check("t3_zero_cycles", zero_cyc, 17);
    check("t3_active", bus.ip_sel_active, 3);
    check("t3_rst", bus.ip_rst_n, 7'b0000100);

    // 4: raw moves to 3 then 5 mid-sequence; 3 completes, 5 follows immediately
    set_raw(1);
    wait_for(0, 40, w);
    set_raw(3);
    wait_for(1, 60, w);
    set_raw(5);
    wait_for(0, 40, w);
    repeat (5) @(negedge sys_clk);
    bus.sel_lock = 1'b1;
    wait_for(1, 60, w);
    bus.sel_lock = 1'b0;
    check("t4_first_active", bus.ip_sel_active, 3);
    @(negedge sys_clk);
    check("t4_back_to_back", bus.busy, 1);
    wait_for(1, 60, w);
    check("t4_active", bus.ip_sel_active, 5);
    check("t4_rst", bus.ip_rst_n, 7'b0010000);

    // 5a: select none
    set_raw(0);
    wait_for(0, 40, w);
    wait_for(1, 60, w);
    check("t5_active", bus.ip_sel_active, 0);
    check("t5_rst", bus.ip_rst_n, 0);
    check("t5_oe", bus.pad_oe_en, 0);

    // 6: lock blocks a start, release starts next cycle, reset aborts in HOLD_RST
    bus.sel_lock = 1'b1;
    set_raw(4);
    busy_cyc = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (bus.busy) busy_cyc++;
    end
    check("t6_locked_busy", busy_cyc, 0);
    bus.sel_lock = 1'b0;
    @(negedge sys_clk);
    check("t6_start_next", bus.busy, 1);
    repeat (ISO + 4) @(negedge sys_clk);
    check("t6_hold_rst", bus.ip_rst_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_active", bus.ip_sel_active, 0);
    check("t6_rst_ip_rst_n", bus.ip_rst_n, 0);
    check("t6_rst_oe", bus.pad_oe_en, 0);
    check("t6_rst_done", bus.switch_done, 0);
    repeat (3) @(negedge sys_clk);
    #2 rst_n = 1'b1;
    wait_for(0, 40, w);
    wait_for(1, 60, w);
    check("t6_reswitch_active", bus.ip_sel_active, 4);
    check("t6_reswitch_rst", bus.ip_rst_n, 7'b0001000);

    // Random phase: held values of varied length, occasional lock
    for (int seg = 0; seg < 60; seg++) begin
      @(negedge sys_clk);
      bus.ip_sel_raw = 3'($urandom_range(0, 7));
      bus.sel_lock   = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 40)) @(negedge sys_clk);
    end
    bus.sel_lock = 1'b0;
    repeat (80) @(negedge sys_clk);

    // 5b: NUM_IP=5 instance, an out-of-range value 6 maps to no IP
    bus5.ip_sel_raw = 3'd2;
    repeat (70) @(negedge sys_clk);
    check("t5b_active2", bus5.ip_sel_active, 2);
    check("t5b_rst2", bus5.ip_rst_n, 5'b00010);
    bus5.ip_sel_raw = 3'd6;
    repeat (70) @(negedge sys_clk);
    check("t5b_invalid", bus5.sel_invalid, 1);
    check("t5b_active0", bus5.ip_sel_active, 0);
    check("t5b_rst0", bus5.ip_rst_n, 0);
    check("t5b_oe0", bus5.pad_oe_en, 0);
    bus5.ip_sel_raw = 3'd3;
    repeat (70) @(negedge sys_clk);
    check("t5b_invalid_clr", bus5.sel_invalid, 0);
    check("t5b_active3", bus5.ip_sel_active, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
